// File: rtl/dut_pkg.sv
// Shared definitions for the DUT interface blocks.
// Record widths, field offsets of the result record {result, cycle_count, timeout},
// field offsets of the expected record {mask, expected}, the verdict record
// layout and the result-checker state encoding.
package dut_pkg;

  localparam int unsigned RTF_WIDTH   = 24;
  localparam int unsigned CYCLE_RANGE = 5;
  localparam int unsigned IDX_WIDTH   = 16;

  localparam int unsigned RES_WIDTH = RTF_WIDTH + CYCLE_RANGE + 1;
  localparam int unsigned EXP_WIDTH = 2 * RTF_WIDTH;
  localparam int unsigned CHK_WIDTH = IDX_WIDTH + RTF_WIDTH + CYCLE_RANGE + 2;

  // Result record {result, cycle_count, timeout}, shared with dut_writeback
  localparam int unsigned RES_TIMEOUT_BIT = 0;
  localparam int unsigned RES_CYCLE_LSB   = 1;
  localparam int unsigned RES_RESULT_LSB  = 1 + CYCLE_RANGE;

  // Expected record {mask, expected}
  localparam int unsigned EXP_VALUE_LSB = 0;
  localparam int unsigned EXP_MASK_LSB  = RTF_WIDTH;

  // Verdict record pushed to the check FIFO
  typedef struct packed {
    logic [IDX_WIDTH-1:0]   index;
    logic [RTF_WIDTH-1:0]   diff;
    logic [CYCLE_RANGE-1:0] cycle_count;
    logic                   timeout;
    logic                   pass;
  } chk_rec_t;

  // Result-checker state encoding
  localparam logic [1:0] ENC_IDLE    = 2'd0;
  localparam logic [1:0] ENC_CAPTURE = 2'd1;
  localparam logic [1:0] ENC_EMIT    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = ENC_IDLE,
    ST_CAPTURE = ENC_CAPTURE,
    ST_EMIT    = ENC_EMIT
  } chk_state_t;

endpackage

// File: rtl/dut_stat_counter.sv
// Saturating statistics counter with synchronous clear and increment enable.
// Ports: clock, reset_n (sync, active-low), clear (zero, wins over inc),
//        inc (count up by one unless already all-ones), count (current value).
module dut_stat_counter
  import dut_pkg::*;
#(
  parameter int unsigned WIDTH = IDX_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Hold at all-ones instead of wrapping
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dut_result_check.sv
// Result checker: pops one result record and one expected record together,
// masks and compares them, and pushes a verdict record to the check FIFO.
// Keeps vector / fail counts and the index of the first failing vector.
// Ports: clock, reset_n (sync, active-low)
//        rfifo_q/rfifo_rdreq/rfifo_rdempty   result FIFO read side (non-show-ahead)
//        efifo_q/efifo_rdreq/efifo_rdempty   expected FIFO read side (non-show-ahead)
//        cfifo_data/cfifo_wrreq/cfifo_wrfull check FIFO write side
//        clear                                zero all statistics
//        vec_count, fail_count, first_fail, first_fail_valid  statistics
//        busy                                 not in IDLE
module dut_result_check
  import dut_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [RES_WIDTH-1:0] rfifo_q,
  output logic                 rfifo_rdreq,
  input  logic                 rfifo_rdempty,
  input  logic [EXP_WIDTH-1:0] efifo_q,
  output logic                 efifo_rdreq,
  input  logic                 efifo_rdempty,
  output logic [CHK_WIDTH-1:0] cfifo_data,
  output logic                 cfifo_wrreq,
  input  logic                 cfifo_wrfull,
  input  logic                 clear,
  output logic [IDX_WIDTH-1:0] vec_count,
  output logic [IDX_WIDTH-1:0] fail_count,
  output logic [IDX_WIDTH-1:0] first_fail,
  output logic                 first_fail_valid,
  output logic                 busy
);

  chk_state_t state;
  logic       clear_pend;

  logic [RTF_WIDTH-1:0]   diff_r;
  logic [CYCLE_RANGE-1:0] cycle_r;
  logic                   timeout_r;
  logic                   pass_r;

  logic [RTF_WIDTH-1:0]   res_value;
  logic [CYCLE_RANGE-1:0] res_cycle;
  logic                   res_timeout;
  logic [RTF_WIDTH-1:0]   exp_value;
  logic [RTF_WIDTH-1:0]   exp_mask;
  logic [RTF_WIDTH-1:0]   cap_diff;

  logic     stat_clr;
  logic     pop;
  logic     push;
  chk_rec_t rec;

  // Unpack the FIFO read data (valid in CAPTURE)
  assign res_value   = rfifo_q[RES_RESULT_LSB +: RTF_WIDTH];
  assign res_cycle   = rfifo_q[RES_CYCLE_LSB +: CYCLE_RANGE];
  assign res_timeout = rfifo_q[RES_TIMEOUT_BIT];
  assign exp_value   = efifo_q[EXP_VALUE_LSB +: RTF_WIDTH];
  assign exp_mask    = efifo_q[EXP_MASK_LSB +: RTF_WIDTH];
  assign cap_diff    = (res_value ^ exp_value) & exp_mask;

  // A pending or fresh clear takes the IDLE cycle; the pop waits one cycle
  assign stat_clr = (state == ST_IDLE) && (clear || clear_pend);
  assign pop      = (state == ST_IDLE) && !stat_clr &&
                    !rfifo_rdempty && !efifo_rdempty && !cfifo_wrfull;
  assign push     = (state == ST_EMIT) && !cfifo_wrfull;

  assign rfifo_rdreq = pop;
  assign efifo_rdreq = pop;
  assign cfifo_wrreq = push;
  assign busy        = (state != ST_IDLE);

  // Verdict record; all fields are registers, so it is stable through EMIT
  always_comb begin
    rec             = '0;
    rec.index       = vec_count;
    rec.diff        = diff_r;
    rec.cycle_count = cycle_r;
    rec.timeout     = timeout_r;
    rec.pass        = pass_r;
  end
  assign cfifo_data = rec;

  // Control FSM, capture registers and first-fail tracking
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      clear_pend       <= 1'b0;
      diff_r           <= '0;
      cycle_r          <= '0;
      timeout_r        <= 1'b0;
      pass_r           <= 1'b0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      // Clear outside IDLE is remembered until the vector in flight is counted
      if (clear && (state != ST_IDLE)) begin
        clear_pend <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (stat_clr) begin
            clear_pend       <= 1'b0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
          end else if (pop) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          diff_r    <= cap_diff;
          cycle_r   <= res_cycle;
          timeout_r <= res_timeout;
          pass_r    <= (cap_diff == '0) && !res_timeout;
          state     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (push) begin
            if (!pass_r && !first_fail_valid) begin
              first_fail       <= vec_count;
              first_fail_valid <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dut_stat_counter #(.WIDTH(IDX_WIDTH)) u_vec_count (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (stat_clr),
    .inc     (push),
    .count   (vec_count)
  );

  dut_stat_counter #(.WIDTH(IDX_WIDTH)) u_fail_count (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (stat_clr),
    .inc     (push && !pass_r),
    .count   (fail_count)
  );

endmodule

// File: tb/tb_dut_result_check.sv
// Bench for dut_result_check: queue-based FIFO models, a reference model that
// pairs loaded records in order and derives each verdict from the comparison rules,
// directed scenarios plus a randomized run with random backpressure.
module tb_dut_result_check;
  import dut_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [RES_WIDTH-1:0] rfifo_q = '0;
  logic                 rfifo_rdreq;
  logic                 rfifo_rdempty = 1'b1;
  logic [EXP_WIDTH-1:0] efifo_q = '0;
  logic                 efifo_rdreq;
  logic                 efifo_rdempty = 1'b1;
  logic [CHK_WIDTH-1:0] cfifo_data;
  logic                 cfifo_wrreq;
  logic                 cfifo_wrfull;
  logic                 clear;
  logic [IDX_WIDTH-1:0] vec_count, fail_count, first_fail;
  logic                 first_fail_valid, busy;

  logic       sc_clear, sc_inc;
  logic [3:0] sc_count;

  always #5 clock = ~clock;

  dut_result_check dut (
    .clock(clock), .reset_n(reset_n),
    .rfifo_q(rfifo_q), .rfifo_rdreq(rfifo_rdreq), .rfifo_rdempty(rfifo_rdempty),
    .efifo_q(efifo_q), .efifo_rdreq(efifo_rdreq), .efifo_rdempty(efifo_rdempty),
    .cfifo_data(cfifo_data), .cfifo_wrreq(cfifo_wrreq), .cfifo_wrfull(cfifo_wrfull),
    .clear(clear), .vec_count(vec_count), .fail_count(fail_count),
    .first_fail(first_fail), .first_fail_valid(first_fail_valid), .busy(busy)
  );

  dut_stat_counter #(.WIDTH(4)) u_sat (
    .clock(clock), .reset_n(reset_n), .clear(sc_clear), .inc(sc_inc), .count(sc_count)
  );

  // FIFO contents and the in-order copy used by the reference model
  logic [RES_WIDTH-1:0] rq[$], mres[$];
  logic [EXP_WIDTH-1:0] eq[$], mexp[$];

  int n_pass = 0, n_checks = 0;
  int cyc = 0, rd_pops = 0, ed_pops = 0, pushes = 0;
  int last_rd_cyc = 0, last_push_cyc = 0;
  logic [CHK_WIDTH-1:0] last_data = '0;
  logic pop_pend_r = 1'b0, pop_pend_e = 1'b0;

  int unsigned m_vec = 0, m_fail = 0, m_ff = 0;
  bit          m_ffv = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] sat16(input int unsigned v);
    return (v > 32'd65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [RES_WIDTH-1:0] mk_res(input logic [23:0] r, input logic [4:0] c, input logic t);
    return {r, c, t};
  endfunction

  function automatic logic [EXP_WIDTH-1:0] mk_exp(input logic [23:0] m, input logic [23:0] e);
    return {m, e};
  endfunction

  task automatic model_zero();
    m_vec = 0; m_fail = 0; m_ff = 0; m_ffv = 1'b0;
  endtask

  // Next verdict from the oldest loaded pair; statistics advance with it
  task automatic check_record();
    logic [RES_WIDTH-1:0] r;
    logic [EXP_WIDTH-1:0] e;
    logic [23:0] res, ex, msk, d;
    logic [4:0]  c;
    logic        t, p;
    if (mres.size() == 0 || mexp.size() == 0) begin
      check("unexpected_push", 64'(1), 64'(0));
      return;
    end
    r = mres.pop_front();
    e = mexp.pop_front();
    res = r[29:6]; c = r[5:1]; t = r[0];
    msk = e[47:24]; ex = e[23:0];
    d = (res ^ ex) & msk;
    p = (d == 24'd0) && !t;
    check("record", 64'(cfifo_data), 64'({sat16(m_vec), d, c, t, p}));
    if (!p) begin
      if (!m_ffv) begin m_ff = m_vec; m_ffv = 1'b1; end
      m_fail++;
    end
    m_vec++;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_vec"},  64'(vec_count),        64'(sat16(m_vec)));
    check({tag, "_fail"}, 64'(fail_count),       64'(sat16(m_fail)));
    check({tag, "_ff"},   64'(first_fail),       64'(sat16(m_ff)));
    check({tag, "_ffv"},  64'(first_fail_valid), 64'(m_ffv));
  endtask

  // Non-show-ahead FIFO read side; flags follow contents one edge later
  always @(posedge clock) begin
    cyc++;
    if (pop_pend_r && rq.size() > 0) rfifo_q <= rq.pop_front();
    if (pop_pend_e && eq.size() > 0) efifo_q <= eq.pop_front();
    rfifo_rdempty <= (rq.size() == 0);
    efifo_rdempty <= (eq.size() == 0);
  end

  // Observe pops and pushes mid-cycle
  always @(negedge clock) begin
    pop_pend_r = rfifo_rdreq;
    pop_pend_e = efifo_rdreq;
    if (reset_n) begin
      if (rfifo_rdreq || efifo_rdreq) begin
        check("pop_pair", 64'(efifo_rdreq), 64'(rfifo_rdreq));
        if (rfifo_rdreq) rd_pops++;
        if (efifo_rdreq) ed_pops++;
        last_rd_cyc = cyc;
      end
      if (cfifo_wrreq) begin
        pushes++;
        last_push_cyc = cyc;
        last_data = cfifo_data;
        check_record();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load_res(input logic [RES_WIDTH-1:0] r);
    rq.push_back(r); mres.push_back(r);
  endtask

  task automatic load_exp(input logic [EXP_WIDTH-1:0] e);
    eq.push_back(e); mexp.push_back(e);
  endtask

  task automatic load(input logic [RES_WIDTH-1:0] r, input logic [EXP_WIDTH-1:0] e);
    load_res(r); load_exp(e);
  endtask

  task automatic drain(input string tag, input int bound);
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (mres.size() == 0 && mexp.size() == 0 && !busy) begin ok = 1'b1; break; end
      tick(1);
    end
    if (!ok) check({tag, "_drain_timeout"}, 64'(0), 64'(1));
  endtask

  // Returns at the start of the CAPTURE cycle that follows a pop
  task automatic wait_pop(input string tag);
    int  p0 = rd_pops;
    bit  ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (rd_pops > p0) begin ok = 1'b1; break; end
    end
    if (!ok) check({tag, "_pop_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(1); clear = 1'b0;
    model_zero();
    tick(1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, e0, k0;
    logic [CHK_WIDTH-1:0] d0;
    logic [23:0] r, ex, msk;
    reset_n = 1'b0; clear = 1'b0; cfifo_wrfull = 1'b0; sc_clear = 1'b0; sc_inc = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Reset state
    check_stats("reset");
    check("reset_busy",  64'(busy),        64'(0));
    check("reset_wrreq", 64'(cfifo_wrreq), 64'(0));

    // Matching vector, latency from pop to push
    load(mk_res(24'h00A5A5, 5'd3, 1'b0), mk_exp(24'hFFFFFF, 24'h00A5A5));
    drain("t1", 20);
    check("t1_latency", 64'(last_push_cyc - last_rd_cyc), 64'(2));
    check("t1_pass_bit", 64'(last_data[0]), 64'(1));
    check_stats("t1");

    // Masked failures; first fail stays on the first one
    do_clear();
    load(mk_res(24'h0000F0, 5'd1, 1'b0), mk_exp(24'h0000FF, 24'h00000F));
    drain("t2a", 20);
    check("t2_diff", 64'(last_data[30:7]), 64'(24'h0000FF));
    check_stats("t2a");
    load(mk_res(24'h123456, 5'd2, 1'b0), mk_exp(24'hFFFFFF, 24'h000000));
    drain("t2b", 20);
    check_stats("t2b");

    // Timeout fails even when data matches
    load(mk_res(24'h00BEEF, 5'd7, 1'b1), mk_exp(24'hFFFFFF, 24'h00BEEF));
    drain("t3", 20);
    check("t3_timeout_bit", 64'(last_data[1]), 64'(1));
    check("t3_pass_bit",    64'(last_data[0]), 64'(0));
    check_stats("t3");

    // Backpressure in EMIT
    load(mk_res(24'h0F0F0F, 5'd9, 1'b0), mk_exp(24'hFFFFFF, 24'h0F0F0F));
    wait_pop("t4");
    cfifo_wrfull = 1'b1;
    tick(1);
    d0 = cfifo_data;
    k0 = pushes;
    for (int i = 0; i < 5; i++) begin
      check("t4_wrreq", 64'(cfifo_wrreq), 64'(0));
      check("t4_data",  64'(cfifo_data),  64'(d0));
      check("t4_vec",   64'(vec_count),   64'(sat16(m_vec)));
      tick(1);
    end
    cfifo_wrfull = 1'b0;
    tick(1);
    check("t4_push", 64'(pushes - k0), 64'(1));
    drain("t4", 20);

    // Full check FIFO blocks pops in IDLE
    cfifo_wrfull = 1'b1;
    p0 = rd_pops;
    load(mk_res(24'h000001, 5'd1, 1'b0), mk_exp(24'hFFFFFF, 24'h000001));
    tick(6);
    check("t5_nopop", 64'(rd_pops - p0), 64'(0));
    cfifo_wrfull = 1'b0;
    drain("t5", 20);
    check("t5_pop", 64'(rd_pops - p0), 64'(1));

    // Unbalanced FIFOs
    p0 = rd_pops; e0 = ed_pops;
    for (int i = 0; i < 3; i++) load_res(mk_res(24'(i + 16), 5'(i), 1'b0));
    tick(6);
    check("t6_nopop", 64'(rd_pops - p0), 64'(0));
    load_exp(mk_exp(24'hFFFFFF, 24'd16));
    tick(10);
    check("t6_rpop", 64'(rd_pops - p0), 64'(1));
    check("t6_epop", 64'(ed_pops - e0), 64'(1));
    load_exp(mk_exp(24'hFFFFFF, 24'd17));
    load_exp(mk_exp(24'hFFFFFF, 24'd99));
    drain("t6", 40);
    check_stats("t6");

    // Clear wins over an eligible pop in the same IDLE cycle
    cfifo_wrfull = 1'b1;
    load(mk_res(24'h000AAA, 5'd2, 1'b0), mk_exp(24'hFFFFFF, 24'h000AAB));
    tick(3);
    p0 = rd_pops;
    cfifo_wrfull = 1'b0;
    clear = 1'b1;
    model_zero();
    tick(1);
    clear = 1'b0;
    check("t7_deferred", 64'(rd_pops - p0), 64'(0));
    drain("t7", 20);
    check_stats("t7");

    // Clear during CAPTURE of vector 7
    do_clear();
    for (int i = 0; i < 7; i++) load(mk_res(24'(i), 5'(i), 1'b0), mk_exp(24'hFFFFFF, 24'(i)));
    drain("t8a", 60);
    load(mk_res(24'h000777, 5'd7, 1'b0), mk_exp(24'hFFFFFF, 24'h000000));
    wait_pop("t8");
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(2);
    check("t8_index7", 64'(last_data[46:31]), 64'(7));
    model_zero();
    check_stats("t8");

    // Reset while a vector is captured: nothing is pushed
    load(mk_res(24'h00C0DE, 5'd4, 1'b0), mk_exp(24'hFFFFFF, 24'h00C0DE));
    wait_pop("t9");
    k0 = pushes;
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    void'(mres.pop_front());
    void'(mexp.pop_front());
    tick(3);
    check("t9_nopush", 64'(pushes - k0), 64'(0));
    check("t9_busy",   64'(busy),        64'(0));
    check_stats("t9");

    // Randomized vectors with random backpressure
    k0 = pushes;
    for (int i = 0; i < 60; i++) begin
      r   = 24'($urandom);
      msk = ($urandom_range(0, 1) == 0) ? 24'hFFFFFF : 24'($urandom);
      case ($urandom_range(0, 2))
        0:       ex = r;
        1:       ex = r ^ (24'd1 << $urandom_range(0, 23));
        default: ex = 24'($urandom);
      endcase
      load(mk_res(r, 5'($urandom), ($urandom_range(0, 7) == 0)), mk_exp(msk, ex));
    end
    for (int k = 0; k < 1000; k++) begin
      if (mres.size() == 0 && !busy) break;
      cfifo_wrfull = ($urandom_range(0, 2) == 0);
      tick(1);
    end
    cfifo_wrfull = 1'b0;
    drain("t10", 400);
    check("t10_pushes", 64'(pushes - k0), 64'(60));
    check_stats("t10");

    // Saturation of the counter at all-ones
    for (int i = 0; i < 20; i++) begin
      sc_inc = 1'b1;
      tick(1);
      if (i == 8) check("sat_mid", 64'(sc_count), 64'(9));
    end
    sc_inc = 1'b0;
    check("sat_top", 64'(sc_count), 64'((20 > 15) ? 15 : 20));
    sc_clear = 1'b1; sc_inc = 1'b1;
    tick(1);
    sc_clear = 1'b0; sc_inc = 1'b0;
    check("sat_clear", 64'(sc_count), 64'(0));

    check("leftover", 64'(mres.size() + mexp.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
